// File: rtl/exec_muldiv_seq_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer:
// funct3 encodings, FSM state encoding and operand-signedness helpers.
package exec_muldiv_seq_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/exec_muldiv_seq_sign_fix.sv
// Final result selection: re-applies operand signs to the unsigned
// magnitude product / quotient / remainder and picks the op's result word.
module muldiv_sign_fix
  import exec_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]        op_i,
  input  logic              neg_i,
  input  logic              rneg_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [XLEN-1:0]   res_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Whole double-width product is negated so MULH* see correct borrows.
  assign prod_s = neg_i  ? -prod_i : prod_i;
  assign quo_s  = neg_i  ? -quo_i  : quo_i;
  assign rem_s  = rneg_i ? -rem_i  : rem_i;

  always_comb begin
    res_o = rem_s;
    case (op_i)
      OP_MUL:                       res_o = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_o = quo_s;
      default:                      res_o = rem_s;
    endcase
  end

endmodule

// File: rtl/exec_muldiv_seq.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply / restoring divide
// on operand magnitudes, one bit per cycle, stalling Execute while busy.
module exec_muldiv_seq
  import exec_muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e            state_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic              rneg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   res_q;
  logic              done_q;

  // Accept-side decode
  logic            a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] amag, bmag, spec_res;

  assign a_neg    = op_a_signed(i_op) & i_rs1[XLEN-1];
  assign b_neg    = op_b_signed(i_op) & i_rs2[XLEN-1];
  assign amag     = a_neg ? -i_rs1 : i_rs1;
  assign bmag     = b_neg ? -i_rs2 : i_rs2;
  assign div_zero = i_op[2] & (i_rs2 == '0);
  assign ovf      = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  // op[1] separates REM/REMU from DIV/DIVU
  assign spec_res = div_zero ? (i_op[1] ? i_rs1 : '1)
                             : (i_op[1] ? '0    : i_rs1);

  // One iteration step; acc_q holds {hi,lo} for MUL and {rem,quo} for DIV
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shf;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign div_shf = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge  = div_shf >= {1'b0, opnd_q};
  assign div_sub = XLEN'(div_shf - {1'b0, opnd_q});

  always_comb begin
    acc_d = acc_q;
    if (state_q == S_MUL)
      acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    else if (state_q == S_DIV)
      acc_d = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                     : {div_shf[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  logic [XLEN-1:0] fix_res;

  // Fed with the post-step value so the result registers on the final step.
  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op_i   (op_q),
    .neg_i  (neg_q),
    .rneg_i (rneg_q),
    .prod_i (acc_d),
    .quo_i  (acc_d[XLEN-1:0]),
    .rem_i  (acc_d[2*XLEN-1:XLEN]),
    .res_o  (fix_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      res_q  <= '0;
      if (i_flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (i_valid) begin
            op_q   <= i_op;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            cnt_q  <= CW'(XLEN);
            if (div_zero || ovf) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= spec_res;
            end else if (!i_op[2]) begin
              state_q <= S_MUL;
              acc_q   <= {{XLEN{1'b0}}, bmag};
              opnd_q  <= amag;
            end else begin
              state_q <= S_DIV;
              acc_q   <= {{XLEN{1'b0}}, amag};
              opnd_q  <= bmag;
            end
          end
          S_MUL, S_DIV: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= fix_res;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_stall  = ((state_q == S_IDLE) & i_valid & ~i_flush) |
                    (state_q == S_MUL) | (state_q == S_DIV);
  assign o_done   = done_q;
  assign o_result = res_q;

endmodule

// File: doc/exec_muldiv_seq.md
Name: exec_muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer attached to the Execute stage.
- Accepts one M-extension operation from Execute and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Holds the pipeline stalled while it runs, then presents the result for exactly one cycle.
- Owns its own datapath registers. The single-cycle ALU is untouched.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_valid  in  1  Execute presents an M-extension op this cycle
- i_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_rs1  in  XLEN  operand A (dividend / multiplicand)
- i_rs2  in  XLEN  operand B (divisor / multiplier)
- i_flush  in  1  pipeline flush; aborts any in-flight op
- o_stall  out  1  freeze upstream stages
- o_done  out  1  result valid pulse
- o_result  out  XLEN  result, valid only while o_done=1

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - State=IDLE, counter=0, all internal registers 0.
  - o_done=0, o_result=0, o_stall=0.
- States: IDLE, MUL, DIV, DONE. State is registered.
- IDLE, i_valid=1, i_flush=0 (accept edge):
  - Latch op, |A|, |B| (magnitudes per signedness of op), result-sign flag and counter=XLEN.
  - Go to MUL (op<4) or DIV (op≥4).
  - Divide by zero (B==0, any div op) goes straight to DONE with result precomputed.
  - Signed overflow (DIV/REM, A=most-negative, B=-1) goes straight to DONE with result precomputed.
- MUL:
  - Each cycle: if multiplier LSB=1, add multiplicand to upper half of a 2·XLEN accumulator; then shift right 1.
  - Decrement counter; counter reaches 0 → DONE.
- DIV:
  - Each cycle: shift the remainder:quotient pair left 1; trial-subtract |B|; if non-negative, keep the difference and set quotient LSB.
  - Decrement counter; counter reaches 0 → DONE.
- DONE:
  - o_done=1, o_result driven, o_stall=0.
  - Next cycle → IDLE unconditionally.
  - i_valid during DONE is ignored (it is the same retiring instruction).
- o_stall = (IDLE & i_valid & ~i_flush) | MUL | DIV. It is combinational so the accept cycle itself stalls.
- Latency: accept at cycle 0; o_done at cycle XLEN+1 for normal ops, cycle 1 for the div-by-zero and overflow special cases.
- Sign fix, applied when entering DONE:
  - MUL: low XLEN of the signed product.
  - MULH, MULHSU, MULHU: high XLEN of the product. Two's-complement the full 2·XLEN product if the sign flag is set.
  - DIV: quotient negated if operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - MULHSU treats A as signed and B as unsigned. All "U" ops use raw operands.
- Special cases:
  - Divide by zero: quotient = all ones; remainder = A.
  - Overflow: quotient = A (most-negative); remainder = 0.
- i_flush=1 in any state: next state IDLE, no o_done. Flush in IDLE also blocks accept that cycle.
- Reset asserted mid-op: immediate IDLE and outputs cleared. No partial result is ever emitted.
- Counter width is clog2(XLEN)+1. No wrap-around occurs because the counter stops at 0.

Decomposition:
- Shared package holds:
  - funct3 constants: OP_MUL … OP_REMU.
  - State encoding localparams: S_IDLE=2'd0, S_MUL=2'd1, S_DIV=2'd2, S_DONE=2'd3.
  - XLEN default.
- One natural sub-module: muldiv_sign_fix (combinational). Inputs: op, sign flags, raw product/quotient/remainder. Output: final o_result.
- FSM and iteration datapath stay in the top module.

Test Plan:
- MUL A=7, B=-3 → o_stall high cycles 0..32, o_done at cycle 33, o_result=0xFFFFFFEB; MULH with the same operands → 0xFFFFFFFF.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFE; MULHSU A=-1, B=2 → 0xFFFFFFFF.
- DIV A=-7, B=2 → quotient 0xFFFFFFFD; REM A=-7, B=2 → 0xFFFFFFFF; DIVU A=100, B=7 → 14; REMU A=100, B=7 → 2.
- DIV A=5, B=0 → o_done at cycle 1, result 0xFFFFFFFF; REM A=5, B=0 → 5; DIV A=0x80000000, B=-1 → 0x80000000, REM → 0.
- Start DIVU, assert i_flush at cycle 10 → IDLE at cycle 11, o_done never asserts, o_stall low; a new op accepted next cycle completes correctly.
- Deassert rst_n at cycle 15 of a MUL → all outputs 0 immediately; after release, MUL 3×4 → 12 with normal latency.
